// File: rtl/hex_pio_blink_pkg.sv
// Register map and CTRL bit positions for the hex digit output PIO.
package hex_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_MASK   = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_PHASE   = 1;
    localparam int CTRL_RESTART = 2;

endpackage

// File: rtl/hex_pio_blink_if.sv
// Avalon-MM slave bus between the Nios II data master and the hex PIO.
interface hex_pio_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, byteenable, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, byteenable, writedata,
        output readdata
    );

endinterface

// File: rtl/hex_pio_blink_timer.sv
// Blink half-period timer: free-running count while enabled, PHASE toggles on each wrap.
//
// state | meaning
// IDLE  | en=0, cnt and PHASE held at 0
// RUN   | en=1, cnt counts up, wraps at BLINK_DIV-1 and toggles PHASE
module hex_pio_blink_timer #(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic phase
);

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_RUN  = 1'b1;
    localparam logic [31:0] CNT_TC  = 32'(BLINK_DIV - 1);

    logic [0:0]  state;
    logic [31:0] cnt_d, cnt_q;
    logic        phase_d, phase_q;

    always_comb begin
        state   = en ? ST_RUN : ST_IDLE;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // restart outranks the wrap so a restart on the terminal cycle leaves PHASE at 0
        if (restart || state == ST_IDLE) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_TC) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/hex_pio_blink.sv
// Parametrised hex digit output PIO: DATA/BLINK_MASK/CTRL register file, set/clear ports, blink blanking.
module hex_pio_blink
    import hex_pio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    hex_pio_blink_if.slave        bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic [DATA_WIDTH-1:0] mask_d, mask_q;
    logic                  en_d, en_q;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] wd_lanes;
    logic                  wr;
    logic                  ctrl_wr;
    logic                  timer_restart;
    logic                  phase;

    always_comb begin
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            lane_mask[i] = bus.byteenable[i / 8];
        end
        wd_lanes = bus.writedata[DATA_WIDTH-1:0] & lane_mask;
        wr       = bus.chipselect & ~bus.write_n;
        ctrl_wr  = wr && (bus.address == ADDR_CTRL) && bus.byteenable[0];

        data_d = data_q;
        mask_d = mask_q;
        en_d   = ctrl_wr ? bus.writedata[CTRL_EN] : en_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_d = (data_q & ~lane_mask) | wd_lanes;
                ADDR_MASK:   mask_d = (mask_q & ~lane_mask) | wd_lanes;
                ADDR_OUTSET: data_d = data_q | wd_lanes;
                ADDR_OUTCLR: data_d = data_q & ~wd_lanes;
                default:     ;
            endcase
        end
        // disabling also clears the timer on the write edge so blanking stops immediately
        timer_restart = ctrl_wr && (bus.writedata[CTRL_RESTART] || !bus.writedata[CTRL_EN]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE[DATA_WIDTH-1:0];
            mask_q <= '0;
            en_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            en_q   <= en_d;
        end
    end

    hex_pio_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en_q),
        .restart (timer_restart),
        .phase   (phase)
    );

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA: bus.readdata = 32'(data_q);
            ADDR_MASK: bus.readdata = 32'(mask_q);
            ADDR_CTRL: begin
                bus.readdata[CTRL_EN]    = en_q;
                bus.readdata[CTRL_PHASE] = phase;
            end
            default:   bus.readdata = '0;
        endcase
    end

    assign out_port = data_q & ~(mask_q & {DATA_WIDTH{phase}});

endmodule

// File: tb/tb_hex_pio_blink.sv
// Bench for hex_pio_blink: directed scenarios plus random bus traffic against a cycle-count model.
module tb_hex_pio_blink;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] out_port;

    hex_pio_blink_if bus ();

    hex_pio_blink #(
        .DATA_WIDTH  (16),
        .RESET_VALUE (32'h0000_00FF),
        .BLINK_DIV   (DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // model: registers plus the edge index at which the current blink run started
    logic [15:0] m_data = 16'h00FF;
    logic [15:0] m_mask = 16'h0;
    logic        m_en   = 1'b0;
    int          m_start = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic exp_phase();
        return m_en && ((((cyc - m_start) / DIV) % 2) == 1);
    endfunction

    function automatic logic [15:0] exp_out();
        return exp_phase() ? (m_data & ~m_mask) : m_data;
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return {16'h0, m_data};
            3'd1:    return {16'h0, m_mask};
            3'd2:    return {30'h0, exp_phase(), m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = 16'h00FF;
        m_mask = 16'h0;
        m_en   = 1'b0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [15:0] bm;
        logic [15:0] v;
        bm = {{8{be[1]}}, {8{be[0]}}};
        v  = wd[15:0] & bm;
        case (a)
            3'd0: m_data = (m_data & ~bm) | v;
            3'd1: m_mask = (m_mask & ~bm) | v;
            3'd2: if (be[0]) begin
                if (wd[2] || (wd[0] && !m_en)) m_start = cyc;
                m_en = wd[0];
            end
            3'd4: m_data = m_data | v;
            3'd5: m_data = m_data & ~v;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
        bus.address    = a;
        bus.byteenable = be;
        bus.writedata  = wd;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        cyc++;
        model_write(a, be, wd);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a);
        bus.address = a;
        #1;
        check(tag, bus.readdata, exp_read(a));
    endtask

    task automatic verify(input string tag);
        check({tag, "_out"}, {16'h0, out_port}, {16'h0, exp_out()});
        read_check({tag, "_rd"}, 3'($urandom_range(0, 7)));
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.byteenable = 4'h0;
        bus.writedata  = 32'h0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_out", {16'h0, out_port}, 32'h0000_00FF);
        read_check("rst_rd0", 3'd0);
        read_check("rst_ctrl", 3'd2);
        read_check("rst_rd3", 3'd3);

        // byte-enabled write
        bus_write(3'd0, 4'hF, 32'h0000_1234);
        bus_write(3'd0, 4'b0010, 32'h0000_ABCD);
        check("be_out", {16'h0, out_port}, 32'h0000_AB34);
        bus_write(3'd1, 4'b0001, 32'hFFFF_5A5A);
        read_check("be_mask", 3'd1);

        // set / clear
        bus_write(3'd0, 4'hF, 32'h0000_00F0);
        bus_write(3'd4, 4'hF, 32'h0000_000F);
        check("set_out", {16'h0, out_port}, 32'h0000_00FF);
        bus_write(3'd5, 4'hF, 32'h0000_0030);
        check("clr_out", {16'h0, out_port}, 32'h0000_00CF);
        read_check("set_rd4", 3'd4);
        read_check("clr_rd5", 3'd5);

        // blink
        bus_write(3'd0, 4'hF, 32'h0000_FFFF);
        bus_write(3'd1, 4'hF, 32'h0000_0F00);
        bus_write(3'd2, 4'h1, 32'h1);
        for (int i = 0; i < 3 * DIV; i++) begin
            check("blink_out", {16'h0, out_port}, ((i / DIV) % 2 == 1) ? 32'h0000_F0FF : 32'h0000_FFFF);
            read_check("blink_ctrl", 3'd2);
            tick();
        end

        // restart on the wrap cycle, then re-enable from idle
        bus_write(3'd2, 4'h1, 32'h0);
        check("dis_out", {16'h0, out_port}, 32'h0000_FFFF);
        bus_write(3'd2, 4'h1, 32'h1);
        repeat (DIV - 1) tick();
        bus_write(3'd2, 4'h1, 32'h5);
        read_check("rs_ctrl", 3'd2);
        check("rs_ctrl_lit", bus.readdata, 32'h1);
        for (int i = 0; i < DIV + 1; i++) begin
            check("rs_out", {16'h0, out_port}, (i == DIV) ? 32'h0000_F0FF : 32'h0000_FFFF);
            if (i < DIV) tick();
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                bus_write(3'($urandom_range(0, 7)), 4'($urandom), (kind == 0) ? 32'($urandom_range(0, 7)) : $urandom);
            end else if (kind == 6) begin
                bus.address    = 3'($urandom_range(0, 7));
                bus.byteenable = 4'hF;
                bus.writedata  = $urandom;
                bus.chipselect = 1'b0;
                bus.write_n    = 1'b0;
                tick();
                bus.write_n    = 1'b1;
            end else begin
                tick();
            end
            verify("rnd");
        end

        // async reset while blanked
        bus_write(3'd1, 4'hF, 32'h0000_FFFF);
        bus_write(3'd2, 4'h1, 32'h1);
        for (int i = 0; i < 2 * DIV && !exp_phase(); i++) tick();
        check("mid_phase", {31'h0, dut.u_timer.phase}, 32'h1);
        bus.address = 3'd2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_out", {16'h0, out_port}, 32'h0000_00FF);
        check("mid_rst_ctrl", bus.readdata, 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            check("post_rst_out", {16'h0, out_port}, 32'h0000_00FF);
            read_check("post_rst_ctrl", 3'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hex_pio_blink.md
# hex_pio_blink

Parametrised Avalon-MM output PIO for the seven-segment hex digit bus. It replaces the fixed 16-bit single-register PIO with several features:

- configurable width and reset value;
- byte-enabled writes;
- atomic bit set/clear registers;
- a hardware blink engine that periodically forces selected output bits low without CPU involvement.

It sits between the Nios II data master and the hex decoder logic.

## Interface
- DATA_WIDTH, 16: width of out_port and of the DATA/BLINK_MASK registers; legal range 1..32.
- RESET_VALUE, 0: reset value of DATA; only bits [DATA_WIDTH-1:0] are used.
- BLINK_DIV, 25000000: clock cycles per blink half-period; legal range 2..2^32-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- byteenable  in  4  byte lanes for the write.
- writedata  in  32  write data.
- readdata  out  32  read data, zero read latency, zero-extended.
- out_port  out  DATA_WIDTH  output to the hex decoders.

## Operation
- A write occurs when chipselect=1 and write_n=0.
- Register map:
  - 0 DATA (RW).
  - 1 BLINK_MASK (RW, reset 0).
  - 2 CTRL (RW): bit0 EN, bit1 PHASE (read-only), bit2 RESTART (write-only, reads 0).
  - 4 OUTSET (WO): DATA |= writedata.
  - 5 OUTCLEAR (WO): DATA &= ~writedata.
  - 3, 6, 7: reserved; read 0, writes ignored.
- Byteenable:
  - applies to DATA, BLINK_MASK, OUTSET and OUTCLEAR per byte lane;
  - bits in disabled lanes are unchanged;
  - bits at or above DATA_WIDTH are ignored.
- CTRL is updated only when byteenable[0]=1.
- readdata is a combinational mux on address, not gated by chipselect. OUTSET and OUTCLEAR read 0.
- out_port = DATA & ~(BLINK_MASK & {DATA_WIDTH{PHASE}}). PHASE=1 blanks the masked bits.
- Blink engine:
  - a 32-bit counter cnt and a PHASE flop, with two states: IDLE (EN=0) and RUN (EN=1).
  - IDLE: cnt=0, PHASE=0. Writing EN=1 enters RUN.
  - RUN: cnt increments every cycle. At cnt==BLINK_DIV-1, cnt wraps to 0 and PHASE toggles.
  - Writing EN=0 returns to IDLE on the next edge; cnt and PHASE are cleared.
  - Writing EN=1 while already in RUN does not restart the count.
  - A write with RESTART=1 clears cnt and PHASE on that edge. If EN=1 in the same write, the block stays or enters RUN from cnt=0.
  - If a RESTART write coincides with the wrap cycle, RESTART wins: PHASE=0, cnt=0.

## Timing
- Reset values: DATA=RESET_VALUE, BLINK_MASK=0, EN=0, cnt=0, PHASE=0.
- Outputs at reset: out_port=RESET_VALUE[DATA_WIDTH-1:0]. readdata is a function of address only (e.g. 0 for addresses other than 0).
- All register updates take place on the rising clk edge of the write cycle. out_port reflects the new value immediately after that edge, i.e. one edge of latency and no extra pipeline stage.
- Reads have zero wait states; readdata is valid in the same cycle as address.
- In RUN, PHASE toggles exactly every BLINK_DIV cycles. The first toggle comes BLINK_DIV edges after the edge that set EN=1.
- An asynchronous reset asserted mid-count immediately clears cnt, PHASE and EN, and restores DATA and BLINK_MASK to their reset values. Nothing is held over.
- Only one Avalon access occurs per cycle, so DATA, OUTSET and OUTCLEAR cannot collide.

## Structure
- Package hex_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_CTRL=2, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - CTRL bit indices CTRL_EN=0, CTRL_PHASE=1, CTRL_RESTART=2.
- Sub-module hex_pio_blink_timer contains cnt and PHASE.
  - Inputs: clk, reset_n, en, restart.
  - Output: phase.
  - Parameter: BLINK_DIV.
- The top level holds the register file, the byteenable merge and the read mux.

## Test plan
1. Reset check, with DATA_WIDTH=16 and RESET_VALUE=0x00FF: after reset_n deasserts, out_port=0x00FF and a read of address 0 returns 0x000000FF.
2. Byte-enabled write: DATA=0x1234, then write 0xABCD to address 0 with byteenable=4'b0010 -> DATA=0xAB34.
3. Set/clear: DATA=0x00F0, write 0x000F to OUTSET -> 0x00FF; write 0x0030 to OUTCLEAR -> 0x00CF; a read of address 4 returns 0.
4. Blink, with BLINK_DIV=4, DATA=0xFFFF and BLINK_MASK=0x0F00: write EN=1 -> out_port shows 0xFFFF for 4 cycles, then 0xF0FF for 4 cycles, and repeats. A CTRL read shows PHASE toggling.
5. Restart on wrap cycle: write CTRL=0x5 on the cycle where cnt==3 -> PHASE stays 0, the next toggle comes 4 cycles later, and CTRL reads back 0x1.
6. Reset mid-run: assert reset_n low while PHASE=1 -> out_port returns to RESET_VALUE asynchronously, EN=0, and no blinking occurs after release.
